monopix_arb_fifo: RTL
=====================

// Module: monopix_arb_fifo
// PURPOSE
//  Word buffer directly downstream of the core's round-robin arbiter output.
//  Accepts 32-bit arbiter words, provides ARB_READY, FIFO_FULL and FIFO_NEAR_FULL backpressure to the core.
//  Streams each stored word to the 16-bit host transfer interface as two halves, low half first.
//  Counts words that were offered while the buffer was full.
// PARAMETERS
//  DEPTH            1024  number of 32-bit words stored; power of two, >=4
//  NEAR_FULL_THRESH 896   FIFO_NEAR_FULL asserted when WORD_COUNT >= this value; must be < DEPTH
//  LOST_W           8     width of the saturating lost-word counter
// PORTS
//  BUS_CLK         in   1          single clock for the whole block (bus clock domain)
//  BUS_RST_N       in   1          asynchronous reset, active low
//  ARB_WRITE       in   1          arbiter write strobe, one word per cycle
//  ARB_DATA        in   32         arbiter data word
//  ARB_READY       out  1          block can accept a word this cycle
//  FIFO_FULL       out  1          WORD_COUNT == DEPTH
//  FIFO_NEAR_FULL  out  1          WORD_COUNT >= NEAR_FULL_THRESH (registered)
//  FIFO_EMPTY      out  1          memory empty and output stage idle
//  OUT_VALID       out  1          OUT_DATA holds a valid half-word
//  OUT_DATA        out  16         current half-word
//  OUT_READY       in   1          host accepts OUT_DATA when OUT_VALID && OUT_READY
//  WORD_COUNT      out  $clog2(DEPTH)+1  words held in memory; excludes the word in the output stage
//  LOST_COUNT      out  LOST_W     words dropped because the buffer was full; saturates
// BEHAVIOUR
//  Reset
//   - BUS_RST_N low clears, asynchronously, all of the following: pointers, WORD_COUNT, LOST_COUNT, the output stage, and the FSM.
//   - Output values while in reset: OUT_VALID=0, OUT_DATA=0, FIFO_FULL=0, FIFO_NEAR_FULL=0, FIFO_EMPTY=1, ARB_READY=0.
//   - ARB_READY stays 0 in the first cycle after reset release. Register rdy_en_q is cleared by reset and set on the first BUS_CLK edge after release.
//  Write side
//   - ARB_READY = rdy_en_q && (WORD_COUNT != DEPTH). The value is taken from the current count, not from any same-cycle pop.
//   - A push happens when ARB_WRITE && ARB_READY. The word is stored at wr_ptr and wr_ptr wraps modulo DEPTH.
//   - When ARB_WRITE && !ARB_READY with rdy_en_q=1, the word is dropped. LOST_COUNT increments and holds at 2^LOST_W-1.
//   - ARB_WRITE while rdy_en_q=0 is ignored and is not counted.
//  Read side, output stage FSM
//   - States: IDLE, LO, HI.
//   - IDLE -> LO: taken when WORD_COUNT != 0. The word at rd_ptr is popped into out_word_q and OUT_VALID=1 from the next cycle. OUT_DATA = out_word_q[15:0].
//   - LO -> HI: taken on OUT_VALID && OUT_READY. OUT_DATA becomes out_word_q[31:16].
//   - HI, on handshake:
//     - if WORD_COUNT != 0: pop the next word and go to LO. No bubble, so back-to-back halves stream at 1 per cycle.
//     - else: go to IDLE with OUT_VALID=0.
//   - OUT_DATA and OUT_VALID hold stable while OUT_VALID && !OUT_READY.
//  Latency
//   - A word pushed at edge N into an empty block is popped at edge N+1.
//   - Its low half is valid after edge N+1 and its high half after the first handshake.
//  Counts and flags
//   - Push and pop in the same cycle leave WORD_COUNT unchanged.
//   - FIFO_FULL is combinational from WORD_COUNT.
//   - FIFO_NEAR_FULL is registered from the next-state count, so it is aligned with WORD_COUNT.
//   - FIFO_EMPTY = (WORD_COUNT==0) && (state==IDLE).
//  Pointer arithmetic
//   - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
//   - WORD_COUNT is kept as an explicit counter, one bit wider than the pointers.
//  Full while popping
//   - When count==DEPTH and a pop happens, a push in that same cycle is refused and counted as lost.
//   - The next cycle accepts writes.
//  Reset mid-stream
//   - Any held or buffered words are discarded with no partial half emitted.
//   - The first half out after reset is from a word written after reset.
// STRUCTURE
//  Package monopix_fifo_pkg:
//   - ARB_DATA_W=32 and OUT_DATA_W=16.
//   - typedef enum {IDLE, LO, HI} out_state_t.
//  Sub-module monopix_sdp_ram:
//   - Simple dual-port memory, DEPTH x 32, with synchronous write and read.
//   - Read-enable driven by the pop, so BRAM inference works. No reset on the array.
//  Top holds: pointers, counters, flags, rdy_en_q, and the output FSM.
// TESTING
//  1. Reset then single word:
//     - Reset, release, then push 32'hDEADBEEF with OUT_READY=1.
//     - Expect OUT_DATA 16'hBEEF then 16'hDEAD on consecutive cycles, then OUT_VALID=0 and FIFO_EMPTY=1.
//  2. Fill to full:
//     - DEPTH=16, NEAR_FULL_THRESH=12, OUT_READY=0. Push words 0..19.
//     - Expect: NEAR_FULL rises when WORD_COUNT reaches 12. Word 0 sits in the output stage, so WORD_COUNT=15 after word 15 is pushed. FULL and ARB_READY=0 after word 16. LOST_COUNT=3.
//  3. Drain with stalls:
//     - After test 2, toggle OUT_READY 1,0,1,0,...
//     - Expect 34 halves, in order (0,0),(1,0),...,(16,0), each stable while stalled. Then FIFO_EMPTY=1.
//  4. Simultaneous push/pop at full:
//     - Hold count=DEPTH, OUT_READY=1 on an HI half, ARB_WRITE=1.
//     - Expect that word refused (LOST +1) and the next-cycle word accepted. WORD_COUNT goes DEPTH -> DEPTH-1 -> DEPTH.
//  5. Saturation:
//     - LOST_W=8, hold full, assert ARB_WRITE for 300 cycles.
//     - Expect LOST_COUNT=255 and held there.
//  6. Reset mid-stream:
//     - Assert BUS_RST_N low while state=HI with 5 words buffered.
//     - Expect outputs at reset values asynchronously, and ARB_READY=0 for one cycle after release.
//     - A new push of 32'h12345678 then yields 16'h5678 first.

Source files
------------

// File: rtl/monopix_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : monopix_fifo_pkg
//  Purpose  : Shared widths and output-stage state encoding for the Monopix
//             arbiter word FIFO.
//  Contents : ARB_DATA_W  - arbiter word width
//             OUT_DATA_W  - host transfer half-word width
//             out_state_t - output stage FSM states
//  Revision : 1.0  initial release
// ============================================================================
package monopix_fifo_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int OUT_DATA_W = 16;

    // IDLE: nothing held; LO: low half presented; HI: high half presented
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/monopix_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module   : monopix_sdp_ram
//  Purpose  : Simple dual-port memory, DEPTH x WIDTH, synchronous write and
//             synchronous registered read. The array carries no reset so
//             that it maps onto block RAM.
//  Ports    : clk_i      - clock
//             wr_en_i    - write enable
//             wr_addr_i  - write address
//             wr_data_i  - write data
//             rd_en_i    - read enable; read register holds when low
//             rd_addr_i  - read address
//             rd_data_o  - registered read data
//  Revision : 1.0  initial release
// ============================================================================
module monopix_sdp_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/monopix_arb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : monopix_arb_fifo
//  Purpose  : Word buffer behind the core round-robin arbiter. Stores 32-bit
//             arbiter words, applies backpressure, streams each word to the
//             16-bit host interface low half first, and counts words that
//             were offered while full.
//  Ports    : BUS_CLK        - clock
//             BUS_RST_N      - asynchronous reset, active low
//             ARB_WRITE      - arbiter write strobe
//             ARB_DATA       - arbiter word
//             ARB_READY      - a word can be accepted this cycle
//             FIFO_FULL      - WORD_COUNT == DEPTH
//             FIFO_NEAR_FULL - WORD_COUNT >= NEAR_FULL_THRESH (registered)
//             FIFO_EMPTY     - memory empty and output stage idle
//             OUT_VALID      - OUT_DATA holds a valid half-word
//             OUT_DATA       - current half-word
//             OUT_READY      - host accepts OUT_DATA
//             WORD_COUNT     - words in memory (excludes output stage word)
//             LOST_COUNT     - saturating count of dropped words
//  Revision : 1.0  initial release
// ============================================================================
module monopix_arb_fifo
    import monopix_fifo_pkg::*;
#(
    parameter int DEPTH            = 1024,
    parameter int NEAR_FULL_THRESH = 896,
    parameter int LOST_W           = 8
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST_N,
    input  logic                     ARB_WRITE,
    input  logic [ARB_DATA_W-1:0]    ARB_DATA,
    output logic                     ARB_READY,
    output logic                     FIFO_FULL,
    output logic                     FIFO_NEAR_FULL,
    output logic                     FIFO_EMPTY,
    output logic                     OUT_VALID,
    output logic [OUT_DATA_W-1:0]    OUT_DATA,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   WORD_COUNT,
    output logic [LOST_W-1:0]        LOST_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]     NF_CNT   = CW'(NEAR_FULL_THRESH);
    localparam logic [LOST_W-1:0] LOST_MAX = '1;

    logic                  rdy_en_q;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic [LOST_W-1:0]     lost_q,   lost_d;
    logic                  near_full_q, near_full_d;
    out_state_t            state_q,  state_d;

    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [ARB_DATA_W-1:0] out_word;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    // Readiness looks only at the current count; a pop in the same cycle
    // does not free a slot until the following cycle.
    assign ARB_READY = rdy_en_q && (count_q != FULL_CNT);
    assign push      = ARB_WRITE && ARB_READY;
    assign drop      = ARB_WRITE && rdy_en_q && (count_q == FULL_CNT);

    // ------------------------------------------------------------------
    // Output stage FSM: next state and pop decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = LO;
                end
            end
            LO: begin
                if (OUT_READY) begin
                    state_d = HI;
                end
            end
            HI: begin
                if (OUT_READY) begin
                    // Refill directly from memory so halves stream without a gap
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = LO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, counters, flags
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        lost_d = lost_q;
        if (drop && (lost_q != LOST_MAX)) begin
            lost_d = lost_q + LOST_W'(1);
        end

        // Registered from the next count so it changes on the same edge as WORD_COUNT
        near_full_d = (count_d >= NF_CNT);
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            rdy_en_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lost_q      <= '0;
            near_full_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            rdy_en_q    <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lost_q      <= lost_d;
            near_full_q <= near_full_d;
            state_q     <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage. The RAM read register doubles as the output word holder:
    // it loads only on a pop and holds otherwise.
    // ------------------------------------------------------------------
    monopix_sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ARB_DATA_W)
    ) u_ram (
        .clk_i     (BUS_CLK),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (ARB_DATA),
        .rd_en_i   (pop),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (out_word)
    );

    // ------------------------------------------------------------------
    // Outputs. OUT_DATA is gated by state so that the unreset RAM read
    // register never leaks out during or after reset.
    // ------------------------------------------------------------------
    always_comb begin
        OUT_DATA = '0;
        case (state_q)
            LO:      OUT_DATA = out_word[OUT_DATA_W-1:0];
            HI:      OUT_DATA = out_word[ARB_DATA_W-1:OUT_DATA_W];
            default: OUT_DATA = '0;
        endcase
    end

    assign OUT_VALID      = (state_q != IDLE);
    assign FIFO_FULL      = (count_q == FULL_CNT);
    assign FIFO_NEAR_FULL = near_full_q;
    assign FIFO_EMPTY     = (count_q == '0) && (state_q == IDLE);
    assign WORD_COUNT     = count_q;
    assign LOST_COUNT     = lost_q;

endmodule
`default_nettype wire
